tristate_bus_ctrl: RTL and testbench
====================================

Name: tristate_bus_ctrl

Overview:
Parametrised, registered bidirectional bus controller. It is the multi-bit successor of the single-bit registered 3-state output. It drives a WIDTH-bit pad group through per-bit O_BUFT/I_BUF primitives, which are instantiated in the top wrapper. It arbitrates direction with a turnaround state machine so that the block's own drive never overlaps a receive window. It also provides a valid/ready transmit interface and a registered receive path.

Parameters:
WIDTH, 8, pad/data bus width in bits (1..64).
TA_CYCLES, 2, number of Hi-Z turnaround cycles on each direction change (0..15).

Ports:
CLK  input  1  single clock; all state updates on the rising edge.
RST_N  input  1  asynchronous active-low reset.
TX_DATA  input  WIDTH  transmit beat.
TX_VALID  input  1  transmit beat valid.
TX_LAST  input  1  marks the final beat of a burst.
TX_READY  output  1  registered; 1 only in the DRIVE state.
RX_DATA  output  WIDTH  registered sample of PAD_I.
RX_VALID  output  1  RX_DATA holds a legal receive-window sample.
BUSY  output  1  registered; state != LISTEN.
PAD_O  output  WIDTH  data to the O_BUFT I pins.
PAD_OE  output  1  common enable to the O_BUFT OE pins (1 = drive).
PAD_I  input  WIDTH  from the I_BUF O pins.
CONTENTION  output  1  sticky readback-mismatch flag (optional feature).

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=LISTEN.
  - PAD_OE=0, PAD_O=0, TX_READY=0, RX_DATA=0, RX_VALID=0, BUSY=0, CONTENTION=0.
  - PAD_OE drops immediately, without waiting for a clock edge, including mid-burst.
- All outputs are flops. There is no combinational path from input to output.
- States: LISTEN, TA_TX, DRIVE, TA_RX. Counter width is 4 bits.
- LISTEN:
  - PAD_OE=0.
  - Every edge: RX_DATA<=PAD_I and RX_VALID<=1.
  - RX_DATA therefore reflects PAD_I from the previous cycle.
  - If TX_VALID=1: go to TA_TX (or straight to DRIVE if TA_CYCLES=0), and RX_VALID<=0 on that edge.
- TA_TX:
  - PAD_OE=0, RX_VALID=0.
  - Lasts exactly TA_CYCLES cycles, then goes to DRIVE.
  - TX_READY<=1 on the entering edge.
  - TX_VALID dropping during TA_TX does not abort the turnaround.
- DRIVE:
  - A beat is accepted when TX_VALID & TX_READY.
  - On acceptance: PAD_O<=TX_DATA and PAD_OE<=1 on the same edge, so stale data is never driven.
  - With no beat: PAD_O holds, and PAD_OE holds its current value (0 before the first beat, 1 after).
  - On an accepted beat with TX_LAST=1: go to TA_RX, TX_READY<=0.
  - TX_LAST on a non-accepted cycle is ignored.
- TA_RX:
  - First cycle: PAD_OE=1, so the last beat is driven for exactly one cycle.
  - Next edge: PAD_OE<=0, then TA_CYCLES further Hi-Z cycles.
  - Then go to LISTEN. RX_VALID first rises on the edge after LISTEN is entered.
  - Total TA_RX duration is TA_CYCLES+1 cycles.
  - TX_VALID in TA_RX is not accepted. It is serviced only after a full return to LISTEN.
- Single-beat burst (TX_LAST on the first beat) is legal: DRIVE lasts one accept cycle.
- Back-to-back bursts always pass through LISTEN for at least one cycle.
- BUSY reflects the registered state.

Optional Feature:
- Macro: TRISTATE_BUS_READBACK_EN.
- When defined:
  - While PAD_OE=1 and the driven value has been stable for at least one cycle, the PAD_I sample registered one cycle later is compared with PAD_O.
  - Any bit mismatch sets CONTENTION<=1 on that edge.
  - CONTENTION is sticky until RST_N.
  - No comparison is made in the first PAD_OE=1 cycle after a 0→1 transition.
- When undefined: the CONTENTION port remains and is constant 0, and no compare logic is generated.

Test Plan:
1. Reset/listen: RST_N=0→1, PAD_I=8'hA5 held → PAD_OE=0 throughout; RX_DATA=8'hA5 and RX_VALID=1 from the 2nd edge after reset release.
2. Burst TA_CYCLES=2: TX_VALID=1 in LISTEN with beats 8'h11, 8'h22, 8'h33 (LAST on 8'h33) →
   - RX_VALID=0 and PAD_OE=0 for 2 cycles; TX_READY=1 at the 3rd edge.
   - PAD_O shows 11/22/33 with PAD_OE=1 on consecutive cycles.
   - PAD_OE=0 exactly 1 cycle after the 8'h33 drive cycle.
   - RX_VALID returns 1 after 2 Hi-Z cycles plus 1 LISTEN cycle.
3. TA_CYCLES=0, single-beat LAST 8'hFF → DRIVE entered on the edge after TX_VALID; PAD_OE=1 for exactly 1 cycle; back to LISTEN with no Hi-Z gap.
4. Stall: TX_VALID dropped mid-burst for 3 cycles after beat 8'h22 → PAD_O=8'h22, PAD_OE=1 and TX_READY=1 held; burst resumes correctly.
5. Async reset mid-burst while PAD_OE=1 → PAD_OE=0 before the next CLK edge; all outputs at reset values.
6. TRISTATE_BUS_READBACK_EN: PAD_I forced to 8'h00 while driving 8'h5A → CONTENTION=1 and stays 1 after the burst ends; cleared only by RST_N. Macro undefined → CONTENTION=0.

Source files
------------

// File: rtl/tristate_bus_ctrl_if.sv
// Bundle of transmit, receive and pad-side signals for tristate_bus_ctrl.
// The master modport is the controller's view and the slave modport is the surrounding logic's view.
interface tristate_bus_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_last;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
    logic [WIDTH-1:0] pad_o;
    logic             pad_oe;
    logic [WIDTH-1:0] pad_i;
    logic             contention;

    modport master (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        input  pad_i,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output busy,
        output pad_o,
        output pad_oe,
        output contention
    );

    modport slave (
        output tx_data,
        output tx_valid,
        output tx_last,
        output pad_i,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  busy,
        input  pad_o,
        input  pad_oe,
        input  contention
    );
endinterface

// File: rtl/tristate_bus_ctrl.sv
// Registered bidirectional pad-group controller with Hi-Z turnaround on every direction change.
// Optional readback contention detection is enabled by defining TRISTATE_BUS_READBACK_EN.
module tristate_bus_ctrl #(
    parameter int WIDTH     = 8,
    parameter int TA_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    tristate_bus_ctrl_if.master bus
);

    localparam logic [3:0] TA_C = 4'(TA_CYCLES);

    typedef enum logic [1:0] {
        ST_LISTEN = 2'd0,
        ST_TA_TX  = 2'd1,
        ST_DRIVE  = 2'd2,
        ST_TA_RX  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_s;
    logic [WIDTH-1:0] pad_o_r;
    logic [WIDTH-1:0] pad_o_s;
    logic [WIDTH-1:0] rx_data_r;
    logic [WIDTH-1:0] rx_data_s;
    logic             pad_oe_r;
    logic             pad_oe_s;
    logic             tx_ready_r;
    logic             tx_ready_s;
    logic             rx_valid_r;
    logic             rx_valid_s;
    logic             busy_r;
    logic             busy_s;
    logic             accept_s;

    assign accept_s = bus.tx_valid & tx_ready_r;

    // Next-state and next-output computation for the direction FSM.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        pad_o_s    = pad_o_r;
        pad_oe_s   = pad_oe_r;
        rx_data_s  = rx_data_r;
        rx_valid_s = 1'b0;
        case (state_r)
            ST_LISTEN: begin
                pad_oe_s  = 1'b0;
                rx_data_s = bus.pad_i;
                if (bus.tx_valid) begin
                    rx_valid_s = 1'b0;
                    if (TA_C == 4'd0) begin
                        state_s = ST_DRIVE;
                    end else begin
                        state_s = ST_TA_TX;
                        cnt_s   = TA_C - 4'd1;
                    end
                end else begin
                    rx_valid_s = 1'b1;
                end
            end
            ST_TA_TX: begin
                // Turnaround runs to completion even if tx_valid drops.
                pad_oe_s = 1'b0;
                if (cnt_r == 4'd0) begin
                    state_s = ST_DRIVE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_DRIVE: begin
                // Data and enable load together so stale data never reaches the pads.
                if (accept_s) begin
                    pad_o_s  = bus.tx_data;
                    pad_oe_s = 1'b1;
                    if (bus.tx_last) begin
                        state_s = ST_TA_RX;
                        cnt_s   = TA_C;
                    end else begin
                        state_s = ST_DRIVE;
                    end
                end else begin
                    pad_o_s  = pad_o_r;
                    pad_oe_s = pad_oe_r;
                end
            end
            ST_TA_RX: begin
                pad_oe_s = 1'b0;
                if (cnt_r == 4'd0) begin
                    state_s = ST_LISTEN;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s  = ST_LISTEN;
                cnt_s    = 4'd0;
                pad_oe_s = 1'b0;
            end
        endcase
        tx_ready_s = (state_s == ST_DRIVE);
        busy_s     = (state_s != ST_LISTEN);
    end

    // State, counter and output registers; reset drops the pad enable immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_LISTEN;
            cnt_r      <= 4'd0;
            pad_o_r    <= '0;
            pad_oe_r   <= 1'b0;
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            pad_o_r    <= pad_o_s;
            pad_oe_r   <= pad_oe_s;
            rx_data_r  <= rx_data_s;
            rx_valid_r <= rx_valid_s;
            tx_ready_r <= tx_ready_s;
            busy_r     <= busy_s;
        end
    end

    assign bus.pad_o    = pad_o_r;
    assign bus.pad_oe   = pad_oe_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.tx_ready = tx_ready_r;
    assign bus.busy     = busy_r;

`ifdef TRISTATE_BUS_READBACK_EN
    function automatic logic word_mismatch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return |(a ^ b);
    endfunction

    logic             prev_oe_r;
    logic [WIDTH-1:0] prev_o_r;
    logic [WIDTH-1:0] samp_r;
    logic [WIDTH-1:0] exp_r;
    logic             chk_r;
    logic             contention_r;

    // A sample qualifies only when the pads were driven with an unchanged value for two cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_oe_r    <= 1'b0;
            prev_o_r     <= '0;
            samp_r       <= '0;
            exp_r        <= '0;
            chk_r        <= 1'b0;
            contention_r <= 1'b0;
        end else begin
            prev_oe_r <= pad_oe_r;
            prev_o_r  <= pad_o_r;
            samp_r    <= bus.pad_i;
            exp_r     <= pad_o_r;
            chk_r     <= pad_oe_r & prev_oe_r & ~word_mismatch(pad_o_r, prev_o_r);
            if (chk_r && word_mismatch(samp_r, exp_r)) begin
                contention_r <= 1'b1;
            end
        end
    end

    assign bus.contention = contention_r;
`else
    assign bus.contention = 1'b0;
`endif

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Bench for tristate_bus_ctrl: two instances (TA_CYCLES=2 and 0) checked every cycle against a
// behavioural window model, with directed steps followed by randomized traffic.
module tb_tristate_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] tx_data_v [2];
    logic       tx_valid_v[2];
    logic       tx_last_v [2];
    logic [7:0] pad_i_v   [2];

    tristate_bus_ctrl_if #(.WIDTH(8)) bus2 ();
    tristate_bus_ctrl_if #(.WIDTH(8)) bus0 ();

    assign bus2.tx_data  = tx_data_v[0];
    assign bus2.tx_valid = tx_valid_v[0];
    assign bus2.tx_last  = tx_last_v[0];
    assign bus2.pad_i    = pad_i_v[0];
    assign bus0.tx_data  = tx_data_v[1];
    assign bus0.tx_valid = tx_valid_v[1];
    assign bus0.tx_last  = tx_last_v[1];
    assign bus0.pad_i    = pad_i_v[1];

    tristate_bus_ctrl #(.WIDTH(8), .TA_CYCLES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));
    tristate_bus_ctrl #(.WIDTH(8), .TA_CYCLES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));

    logic [7:0] obs_pad_o[2];
    logic [7:0] obs_rx_data[2];
    logic       obs_pad_oe[2];
    logic       obs_ready[2];
    logic       obs_rx_valid[2];
    logic       obs_busy[2];
    logic       obs_cont[2];

    assign obs_pad_o[0]    = bus2.pad_o;
    assign obs_pad_o[1]    = bus0.pad_o;
    assign obs_rx_data[0]  = bus2.rx_data;
    assign obs_rx_data[1]  = bus0.rx_data;
    assign obs_pad_oe[0]   = bus2.pad_oe;
    assign obs_pad_oe[1]   = bus0.pad_oe;
    assign obs_ready[0]    = bus2.tx_ready;
    assign obs_ready[1]    = bus0.tx_ready;
    assign obs_rx_valid[0] = bus2.rx_valid;
    assign obs_rx_valid[1] = bus0.rx_valid;
    assign obs_busy[0]     = bus2.busy;
    assign obs_busy[1]     = bus0.busy;
    assign obs_cont[0]     = bus2.contention;
    assign obs_cont[1]     = bus0.contention;

    // Reference model: the burst is a window of pre-turnaround, acceptance and release phases.
    int         ta_of[2] = '{2, 0};
    logic [7:0] e_o[2];
    logic [7:0] e_rxd[2];
    logic       e_oe[2];
    logic       e_ready[2];
    logic       e_rxv[2];
    int         pre_left[2];
    int         post_left[2];
    bit         in_burst[2];
    bit         releasing[2];

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic model_reset(input int i);
        e_o[i] = 8'h00; e_rxd[i] = 8'h00; e_oe[i] = 1'b0; e_ready[i] = 1'b0; e_rxv[i] = 1'b0;
        pre_left[i] = 0; post_left[i] = 0; in_burst[i] = 1'b0; releasing[i] = 1'b0;
    endtask

    task automatic model_edge(input int i);
        if (releasing[i]) begin
            e_oe[i] = 1'b0;
            e_rxv[i] = 1'b0;
            if (post_left[i] == 0) releasing[i] = 1'b0;
            else post_left[i] = post_left[i] - 1;
        end else if (pre_left[i] > 0) begin
            e_rxv[i] = 1'b0;
            pre_left[i] = pre_left[i] - 1;
            if (pre_left[i] == 0) in_burst[i] = 1'b1;
        end else if (in_burst[i]) begin
            e_rxv[i] = 1'b0;
            if (tx_valid_v[i]) begin
                e_o[i] = tx_data_v[i];
                e_oe[i] = 1'b1;
                if (tx_last_v[i]) begin
                    in_burst[i] = 1'b0;
                    releasing[i] = 1'b1;
                    post_left[i] = ta_of[i];
                end
            end
        end else begin
            e_rxd[i] = pad_i_v[i];
            e_oe[i] = 1'b0;
            if (tx_valid_v[i]) begin
                e_rxv[i] = 1'b0;
                if (ta_of[i] == 0) in_burst[i] = 1'b1;
                else pre_left[i] = ta_of[i];
            end else begin
                e_rxv[i] = 1'b1;
            end
        end
        e_ready[i] = in_burst[i];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit with_cont);
        for (int i = 0; i < 2; i++) begin
            string nm;
            nm = (i == 0) ? "ta2" : "ta0";
            check({nm, " pad_oe"},   64'(obs_pad_oe[i]),   64'(e_oe[i]));
            check({nm, " pad_o"},    64'(obs_pad_o[i]),    64'(e_o[i]));
            check({nm, " tx_ready"}, 64'(obs_ready[i]),    64'(e_ready[i]));
            check({nm, " rx_data"},  64'(obs_rx_data[i]),  64'(e_rxd[i]));
            check({nm, " rx_valid"}, 64'(obs_rx_valid[i]), 64'(e_rxv[i]));
            check({nm, " busy"},     64'(obs_busy[i]),
                  64'(releasing[i] || in_burst[i] || (pre_left[i] > 0)));
            if (with_cont) check({nm, " contention"}, 64'(obs_cont[i]), 64'd0);
        end
    endtask

    bit chk_cont;

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_reset(i);
            else model_edge(i);
        end
        #1;
        check_all(chk_cont);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tx_valid_v[i] = 1'b0; tx_last_v[i] = 1'b0; tx_data_v[i] = 8'h00;
        end
    endtask

    initial begin
`ifdef TRISTATE_BUS_READBACK_EN
        chk_cont = 1'b0;
`else
        chk_cont = 1'b1;
`endif
        rst_n = 1'b0;
        idle_inputs();
        pad_i_v[0] = 8'hA5;
        pad_i_v[1] = 8'hA5;
        #1;
        model_reset(0);
        model_reset(1);
        check_all(1'b1);
        step();
        step();
        #2 rst_n = 1'b1;

        // Listening after reset release
        step();
        step();
        check("listen rx_data",  64'(obs_rx_data[0]),  64'h00000000000000A5);
        check("listen rx_valid", 64'(obs_rx_valid[0]), 64'd1);
        check("listen pad_oe",   64'(obs_pad_oe[0]),   64'd0);
        step();

        // Three-beat burst with a stall after the second beat, TA_CYCLES=2
        tx_valid_v[0] = 1'b1; tx_data_v[0] = 8'h11; tx_last_v[0] = 1'b0;
        step();
        check("ta_tx rx_valid", 64'(obs_rx_valid[0]), 64'd0);
        step();
        check("ta_tx pad_oe", 64'(obs_pad_oe[0]), 64'd0);
        step();
        check("drive entry ready", 64'(obs_ready[0]), 64'd1);
        check("drive entry pad_oe", 64'(obs_pad_oe[0]), 64'd0);
        step();
        check("beat1 pad_o", 64'(obs_pad_o[0]), 64'h11);
        check("beat1 pad_oe", 64'(obs_pad_oe[0]), 64'd1);
        tx_data_v[0] = 8'h22;
        step();
        check("beat2 pad_o", 64'(obs_pad_o[0]), 64'h22);
        tx_valid_v[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall pad_o", 64'(obs_pad_o[0]), 64'h22);
            check("stall pad_oe", 64'(obs_pad_oe[0]), 64'd1);
            check("stall ready", 64'(obs_ready[0]), 64'd1);
        end
        tx_valid_v[0] = 1'b1; tx_data_v[0] = 8'h33; tx_last_v[0] = 1'b1;
        step();
        check("beat3 pad_o", 64'(obs_pad_o[0]), 64'h33);
        check("beat3 pad_oe", 64'(obs_pad_oe[0]), 64'd1);
        check("beat3 ready", 64'(obs_ready[0]), 64'd0);
        idle_inputs();
        step();
        check("release pad_oe", 64'(obs_pad_oe[0]), 64'd0);
        step();
        step();
        check("back to listen busy", 64'(obs_busy[0]), 64'd0);
        check("back to listen rx_valid", 64'(obs_rx_valid[0]), 64'd0);
        step();
        check("rx_valid returns", 64'(obs_rx_valid[0]), 64'd1);

        // Single-beat burst with TA_CYCLES=0
        tx_valid_v[1] = 1'b1; tx_data_v[1] = 8'hFF; tx_last_v[1] = 1'b1;
        step();
        check("ta0 drive ready", 64'(obs_ready[1]), 64'd1);
        check("ta0 drive pad_oe", 64'(obs_pad_oe[1]), 64'd0);
        step();
        check("ta0 beat pad_o", 64'(obs_pad_o[1]), 64'hFF);
        check("ta0 beat pad_oe", 64'(obs_pad_oe[1]), 64'd1);
        idle_inputs();
        step();
        check("ta0 release pad_oe", 64'(obs_pad_oe[1]), 64'd0);
        check("ta0 release busy", 64'(obs_busy[1]), 64'd0);
        step();

        // Asynchronous reset while driving
        tx_valid_v[0] = 1'b1; tx_data_v[0] = 8'h44; tx_last_v[0] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("pre-reset pad_oe", 64'(obs_pad_oe[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset pad_oe", 64'(obs_pad_oe[0]), 64'd0);
        model_reset(0);
        model_reset(1);
        check_all(1'b1);
        idle_inputs();
        step();
        #2 rst_n = 1'b1;
        step();

        // Randomized traffic on both instances
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 2; i++) begin
                tx_valid_v[i] = ($urandom_range(0, 9) < 7);
                tx_data_v[i]  = 8'($urandom);
                tx_last_v[i]  = ($urandom_range(0, 3) == 0);
                pad_i_v[i]    = 8'($urandom);
            end
            step();
        end
        idle_inputs();
        for (int k = 0; k < 6; k++) step();

`ifdef TRISTATE_BUS_READBACK_EN
        // Readback: pads held low while driving 8'h5A
        rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
        pad_i_v[0] = 8'h00;
        tx_valid_v[0] = 1'b1; tx_data_v[0] = 8'h5A; tx_last_v[0] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        tx_valid_v[0] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("contention set", 64'(obs_cont[0]), 64'd1);
        tx_valid_v[0] = 1'b1; tx_last_v[0] = 1'b1;
        step();
        idle_inputs();
        for (int k = 0; k < 5; k++) step();
        check("contention sticky", 64'(obs_cont[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("contention cleared", 64'(obs_cont[0]), 64'd0);
        step();
        #2 rst_n = 1'b1;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
